// File: rtl/mmm_pkg.sv
// mmm_pkg: shared front-end constants and the BTB flush FSM state type.
//   XLEN          address/target width
//   OFFSET        PC bits below the BTB set index (instruction alignment)
//   BTB_SET_BITS  default log2(number of BTB sets)
//   BTB_WAYS      default BTB associativity
package mmm_pkg;
  localparam int XLEN         = 32;
  localparam int OFFSET       = 2;
  localparam int BTB_SET_BITS = 4;
  localparam int BTB_WAYS     = 2;

  typedef enum logic [0:0] {
    BTB_IDLE  = 1'b0,
    BTB_FLUSH = 1'b1
  } btb_fsm_e;
endpackage

// File: rtl/btb_way_sel.sv
// btb_way_sel: combinational way selection for one BTB set.
//   i_valid      per-way valid bits
//   i_match      per-way tag-compare results
//   i_victim     round-robin victim pointer of the set
//   o_hit        some valid way matches
//   o_hit_way    lowest matching way (0 when no hit)
//   o_has_inv    some way is invalid
//   o_first_inv  lowest invalid way (0 when none)
//   o_wr_way     way an update writes: hit way, else first invalid, else victim
//   o_use_victim update falls back to the victim (caller advances the pointer)
module btb_way_sel #(
  parameter int WAYS     = 2,
  parameter int WAY_BITS = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]     i_valid,
  input  logic [WAYS-1:0]     i_match,
  input  logic [WAY_BITS-1:0] i_victim,
  output logic                o_hit,
  output logic [WAY_BITS-1:0] o_hit_way,
  output logic                o_has_inv,
  output logic [WAY_BITS-1:0] o_first_inv,
  output logic [WAY_BITS-1:0] o_wr_way,
  output logic                o_use_victim
);
  logic [WAYS-1:0] w_hit_vec;

  assign w_hit_vec = i_valid & i_match;

  // Scan from the top way down so the lowest qualifying way is the last writer.
  always_comb begin
    o_hit       = 1'b0;
    o_hit_way   = '0;
    o_has_inv   = 1'b0;
    o_first_inv = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) begin
        o_hit     = 1'b1;
        o_hit_way = WAY_BITS'(w);
      end
      if (!i_valid[w]) begin
        o_has_inv   = 1'b1;
        o_first_inv = WAY_BITS'(w);
      end
    end
  end

  assign o_use_victim = !o_hit && !o_has_inv;
  assign o_wr_way     = o_hit ? o_hit_way : (o_has_inv ? o_first_inv : i_victim);
endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer for the fetch stage.
//   clk_i         clock, rising edge
//   rst_n_i       asynchronous reset, active low
//   flush_i       start a one-set-per-cycle invalidation sweep
//   pc_i          lookup PC (combinational lookup)
//   valid_i       branch resolution valid
//   del_entry_i   with valid_i: delete the entry for update_pc_i
//   update_pc_i   PC of the resolved branch
//   target_i      resolved target
//   hit_o         lookup hit
//   hit_way_o     way that hit (0 on miss)
//   pred_target_o predicted target (0 on miss)
//   busy_o        flush sweep in progress
module btb_assoc #(
  parameter int XLEN     = mmm_pkg::XLEN,
  parameter int OFFSET   = mmm_pkg::OFFSET,
  parameter int SET_BITS = mmm_pkg::BTB_SET_BITS,
  parameter int WAYS     = mmm_pkg::BTB_WAYS,
  parameter int WAY_BITS = $clog2(WAYS)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                flush_i,
  input  logic [XLEN-1:0]     pc_i,
  input  logic                valid_i,
  input  logic                del_entry_i,
  input  logic [XLEN-1:0]     update_pc_i,
  input  logic [XLEN-1:0]     target_i,
  output logic                hit_o,
  output logic [WAY_BITS-1:0] hit_way_o,
  output logic [XLEN-1:0]     pred_target_o,
  output logic                busy_o
);
  import mmm_pkg::*;

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = XLEN - SET_BITS - OFFSET;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } entry_t;

  entry_t              r_mem    [SETS][WAYS];
  logic [WAY_BITS-1:0] r_victim [SETS];
  logic [SET_BITS-1:0] r_flush_cnt;
  btb_fsm_e            r_state;

  logic [SET_BITS-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0]    w_lk_tag, w_up_tag;
  logic [WAYS-1:0]     w_lk_valid, w_lk_match, w_up_valid, w_up_match;
  logic                w_lk_hit, w_up_hit, w_up_use_victim, w_busy;
  logic [WAY_BITS-1:0] w_lk_hit_way, w_up_hit_way, w_up_wr_way;
  logic                w_lk_has_inv_unused, w_up_has_inv_unused, w_lk_use_victim_unused;
  logic [WAY_BITS-1:0] w_lk_first_inv_unused, w_lk_wr_way_unused, w_up_first_inv_unused;
  logic                w_unused_pc_bits;

  assign w_lk_idx = pc_i[SET_BITS+OFFSET-1:OFFSET];
  assign w_lk_tag = pc_i[XLEN-1:SET_BITS+OFFSET];
  assign w_up_idx = update_pc_i[SET_BITS+OFFSET-1:OFFSET];
  assign w_up_tag = update_pc_i[XLEN-1:SET_BITS+OFFSET];
  assign w_unused_pc_bits = ^{pc_i[OFFSET-1:0], update_pc_i[OFFSET-1:0]};

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way_cmp
      assign w_lk_valid[gi] = r_mem[w_lk_idx][gi].valid;
      assign w_lk_match[gi] = (r_mem[w_lk_idx][gi].tag == w_lk_tag);
      assign w_up_valid[gi] = r_mem[w_up_idx][gi].valid;
      assign w_up_match[gi] = (r_mem[w_up_idx][gi].tag == w_up_tag);
    end
  endgenerate

  btb_way_sel #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_lookup_sel (
    .i_valid      (w_lk_valid),
    .i_match      (w_lk_match),
    .i_victim     ('0),
    .o_hit        (w_lk_hit),
    .o_hit_way    (w_lk_hit_way),
    .o_has_inv    (w_lk_has_inv_unused),
    .o_first_inv  (w_lk_first_inv_unused),
    .o_wr_way     (w_lk_wr_way_unused),
    .o_use_victim (w_lk_use_victim_unused)
  );

  btb_way_sel #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_update_sel (
    .i_valid      (w_up_valid),
    .i_match      (w_up_match),
    .i_victim     (r_victim[w_up_idx]),
    .o_hit        (w_up_hit),
    .o_hit_way    (w_up_hit_way),
    .o_has_inv    (w_up_has_inv_unused),
    .o_first_inv  (w_up_first_inv_unused),
    .o_wr_way     (w_up_wr_way),
    .o_use_victim (w_up_use_victim)
  );

  assign w_busy        = (r_state == BTB_FLUSH);
  assign busy_o        = w_busy;
  // Lookups are masked for the whole sweep, even for sets already cleared.
  assign hit_o         = w_lk_hit && !w_busy;
  assign hit_way_o     = hit_o ? w_lk_hit_way : '0;
  assign pred_target_o = hit_o ? r_mem[w_lk_idx][w_lk_hit_way].target : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_mem[s][w] <= '0;
        end
        r_victim[s] <= '0;
      end
      r_flush_cnt <= '0;
      r_state     <= BTB_IDLE;
    end else begin
      case (r_state)
        BTB_IDLE: begin
          // A flush request takes priority and drops a same-cycle update.
          if (flush_i) begin
            r_state     <= BTB_FLUSH;
            r_flush_cnt <= '0;
          end else if (valid_i) begin
            if (del_entry_i) begin
              if (w_up_hit) begin
                r_mem[w_up_idx][w_up_hit_way].valid <= 1'b0;
              end
            end else begin
              r_mem[w_up_idx][w_up_wr_way] <= entry_t'{valid: 1'b1, tag: w_up_tag, target: target_i};
              if (w_up_use_victim) begin
                r_victim[w_up_idx] <= r_victim[w_up_idx] + WAY_BITS'(1);
              end
            end
          end
        end
        BTB_FLUSH: begin
          for (int w = 0; w < WAYS; w++) begin
            r_mem[r_flush_cnt][w].valid <= 1'b0;
          end
          r_victim[r_flush_cnt] <= '0;
          r_flush_cnt           <= r_flush_cnt + SET_BITS'(1);
          if (r_flush_cnt == SET_BITS'(SETS - 1)) begin
            r_state <= BTB_IDLE;
          end
        end
        default: r_state <= BTB_IDLE;
      endcase
    end
  end
endmodule
